// File: rtl/fetch_if.sv
// Qu fetch-stage bus: instruction-memory request/response, redirect input and decode handshake.
// master = fetch stage, slave = environment (memory, branch unit, decode).
interface fetch_if #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned PC_WIDTH    = 32
);
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [PC_WIDTH-1:0]    imem_req_addr;
  logic                   imem_rsp_valid;
  logic [INSTR_WIDTH-1:0] imem_rsp_data;
  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   dec_valid;
  logic                   dec_ready;
  logic [INSTR_WIDTH-1:0] dec_instr;
  logic [PC_WIDTH-1:0]    dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch.sv
// Qu instruction fetch stage: issues in-order word fetches, buffers responses with their PCs in a
// small FIFO and hands them to decode. Redirects flush the FIFO and drop stale in-flight responses.
// Optional feature macro: QU_FETCH_MISALIGN_CHECK_EN (adds fetch_misaligned and halts on a
// misaligned redirect target until the next aligned redirect).
module fetch #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input logic     clk,
  input logic     rst,
`ifdef QU_FETCH_MISALIGN_CHECK_EN
  output logic    fetch_misaligned,
`endif
  fetch_if.master bus
);

  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef logic [PC_WIDTH-1:0] pc_t;
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [PTR_W-1:0]    ptr_t;

  pc_t                    pc_q, pc_d;
  pc_t                    rsp_pc_q, rsp_pc_d;
  cnt_t                   count_q, count_d;
  cnt_t                   outst_q, outst_d;
  cnt_t                   drop_q, drop_d;
  ptr_t                   wr_ptr_q, wr_ptr_d;
  ptr_t                   rd_ptr_q, rd_ptr_d;
  logic [INSTR_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];
  pc_t                    pc_mem_q    [FIFO_DEPTH];

  logic                   halt;
  logic                   credit;
  logic                   req_valid;
  logic                   req_hs;
  logic                   dec_valid;
  logic                   pop;
  logic                   push;
  logic [CNT_W:0]         inflight;
  pc_t                    target;

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

`ifdef QU_FETCH_MISALIGN_CHECK_EN
  logic halt_q;
  logic misaligned_q;

  // Misaligned redirect: one-cycle flag and request halt until the next aligned redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      if (bus.redirect_valid) begin
        halt_q <= (bus.redirect_pc[1:0] != 2'b00);
      end
    end
  end

  assign halt             = halt_q;
  assign fetch_misaligned = misaligned_q;
`else
  assign halt = 1'b0;
`endif

  // Outstanding plus buffered entries never exceed the FIFO depth, so every response has a slot.
  assign inflight  = {1'b0, count_q} + {1'b0, outst_q};
  assign credit    = inflight < (CNT_W + 1)'(FIFO_DEPTH);
  assign req_valid = !rst && !bus.redirect_valid && credit && !halt;
  assign req_hs    = req_valid && bus.imem_req_ready;
  assign dec_valid = (count_q != '0) && !bus.redirect_valid;
  assign pop       = dec_valid && bus.dec_ready;
  assign push      = bus.imem_rsp_valid && !bus.redirect_valid && (drop_q == '0);
  assign target    = bus.redirect_pc & ~pc_t'(3);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.dec_valid      = dec_valid;
  assign bus.dec_instr      = instr_mem_q[rd_ptr_q];
  assign bus.dec_pc         = pc_mem_q[rd_ptr_q];

  // Next-state: redirect wins over everything; otherwise advance PCs, counters and pointers.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    count_d  = count_q;
    drop_d   = drop_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    outst_d  = outst_q + cnt_t'(req_hs) - cnt_t'(bus.imem_rsp_valid);
    if (bus.redirect_valid) begin
      pc_d     = target;
      rsp_pc_d = target;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      // Everything still in flight after this cycle belongs to the old path.
      drop_d   = outst_d;
    end else begin
      if (req_hs) begin
        pc_d = pc_q + pc_t'(4);
      end
      if (bus.imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else begin
          rsp_pc_d = rsp_pc_q + pc_t'(4);
          wr_ptr_d = ptr_inc(wr_ptr_q);
        end
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      count_q  <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so the decode outputs read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

endmodule
